regfile_write_sched: RTL
========================

Name: regfile_write_sched

Overview:
- Schedules all writes into the single write port (we3/wa3/wd3) of the 32x32 register file. Sources include ALU writeback, load writeback and the debug/loader port.
- Arbitrates NREQ requesters round-robin, with a valid/ready handshake per requester.
- Provides a sequenced clear sweep that writes zero to x1..x31 without asserting the global reset.
- Sits between the writeback stage and the register file.

Parameters:
- NREQ, 3, number of write requesters (2..8); index 0 is highest priority after reset.
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk, input, 1, clock, rising-edge.
- rst, input, 1, asynchronous active-low reset.
- req_valid, input, NREQ, per-requester write request.
- req_ready, output, NREQ, per-requester grant; handshake when valid & ready.
- req_addr, input, NREQ*AW, packed destination addresses; requester i occupies bits [i*AW +: AW].
- req_data, input, NREQ*DW, packed write data; requester i occupies bits [i*DW +: DW].
- clear_start, input, 1, single-cycle pulse that requests a clear sweep.
- busy, output, 1, high while the clear sweep runs.
- clear_done, output, 1, one-cycle pulse when the sweep completes.
- we3, output, 1, register-file write enable (registered).
- wa3, output, AW, register-file write address (registered).
- wd3, output, DW, register-file write data (registered).

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, rr pointer=0.
  - we3=0, wa3=0, wd3=0.
  - busy=0, clear_done=0.
  - req_ready=0 while rst is low.
- States: IDLE, CLEAR.
- IDLE arbitration:
  - req_ready is combinational: at most one bit high, only for a requester with valid=1.
  - Winner is the first valid requester searching upward from rr pointer, wrapping modulo NREQ.
  - After a handshake by requester i, rr pointer becomes (i+1) mod NREQ. Without a handshake the pointer holds.
  - Requesters hold valid/addr/data stable until the handshake.
- Write latency:
  - A handshake in cycle N drives we3=1 and wa3/wd3 = the winner's addr/data in cycle N+1.
  - Otherwise we3=0 in cycle N+1.
  - wa3/wd3 hold their last value when we3=0.
- Address 0:
  - The handshake completes normally (ready=1) and the rr pointer advances.
  - we3 stays 0 the next cycle, so x0 is never written.
- Throughput: one write per cycle, with no idle cycle between back-to-back grants.
- Entering CLEAR:
  - clear_start=1 in IDLE takes priority over requests: req_ready=0 that cycle.
  - Next state is CLEAR, the internal counter loads 1, and busy=1 from the next cycle.
- CLEAR sweep:
  - Each cycle: we3=1, wa3=counter, wd3=0, then counter increments.
  - Covers addresses 1..31: 31 consecutive write cycles, with busy high for exactly those 31 cycles.
  - req_ready=0 for all requesters throughout; pending requests wait and are not lost.
  - clear_start during CLEAR is ignored.
- Leaving CLEAR:
  - After the wa3=31 write, state returns to IDLE.
  - clear_done=1 for one cycle, in the first cycle with busy=0.
  - Arbitration may grant in that same cycle.
  - The rr pointer is unchanged by the sweep.
- Reset mid-sweep: immediate abort to the reset values; no clear_done pulse.
- No requests and no clear: outputs idle with we3=0.

Test Plan:
- After reset, requesters 0, 1 and 2 all valid with addrs 5/6/7 and data A/B/C -> grants occur in order 0, 1, 2 on consecutive cycles. we3 is 1 for 3 cycles, with (wa3,wd3) = (5,A), (6,B), (7,C), each one cycle after its handshake.
- Requester 2 valid alone, then requesters 0 and 2 valid together -> after the grant to 2, the rr pointer is 0 and requester 0 wins next.
- Requester 1 writes addr 0, data 0xDEADBEEF -> req_ready[1]=1 for one cycle, we3 stays 0 and the pointer advances to 2.
- clear_start pulse with requester 0 valid in the same cycle -> no grant that cycle. busy is high for 31 cycles with wa3=1..31, wd3=0, we3=1. clear_done pulses once. Requester 0 is then granted and its write appears on the following cycle.
- rst low at sweep cycle 10 (wa3=10) -> we3, wa3, wd3 and busy go to 0 immediately with no clear_done pulse. After rst is released, a new clear_start runs a full 31-write sweep.
- Continuous valid on requester 0 alone for 8 cycles with addrs 1..8 -> 8 back-to-back writes with we3 held at 1 and no gaps.

Source files
------------

// File: rtl/regfile_write_sched.sv
// ----------------------------------------------------------------------------
// regfile_write_sched
//
// Purpose:
//   Owns the single write port (we3/wa3/wd3) of the 32x32 register file.
//   NREQ writeback sources (ALU, load, debug/loader, ...) compete for the port
//   through a round-robin arbiter with a valid/ready handshake per requester.
//   A clear sweep writes zero to x1..x(2^AW-1) without using the global reset.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   req_valid    per-requester write request
//   req_ready    per-requester grant (combinational, one-hot or zero)
//   req_addr     packed destination addresses, requester i at [i*AW +: AW]
//   req_data     packed write data, requester i at [i*DW +: DW]
//   clear_start  single-cycle pulse requesting a clear sweep
//   busy         high while the clear sweep drives the write port
//   clear_done   one-cycle pulse in the first cycle after the sweep
//   we3/wa3/wd3  registered register-file write port
// ----------------------------------------------------------------------------
module regfile_write_sched #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 clear_start,
    output logic                 busy,
    output logic                 clear_done,
    output logic                 we3,
    output logic [AW-1:0]        wa3,
    output logic [DW-1:0]        wd3
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_rr;          // requester searched first
    logic [AW-1:0]   r_cnt;         // next sweep address; wraps to 0 after the last one
    logic            r_we3;
    logic [AW-1:0]   r_wa3;
    logic [DW-1:0]   r_wd3;
    logic            r_busy;
    logic            r_clear_done;

    logic            w_found;
    logic [PW-1:0]   w_win_idx;
    logic [AW-1:0]   w_win_addr;
    logic [DW-1:0]   w_win_data;
    logic            w_grant_en;

    // (base + off) mod NREQ, valid for base < NREQ and off <= NREQ
    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end else begin
            s = s;
        end
        return s[PW-1:0];
    endfunction

    // Round-robin search: first valid requester at or above r_rr, wrapping
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[rr_index(r_rr, k)]) begin
                w_found   = 1'b1;
                w_win_idx = rr_index(r_rr, k);
            end else begin
                w_found   = w_found;
            end
        end
    end

    assign w_win_addr = req_addr[int'(w_win_idx)*AW +: AW];
    assign w_win_data = req_data[int'(w_win_idx)*DW +: DW];

    // A grant needs reset released, IDLE state and no clear request this cycle
    assign w_grant_en = rst && (r_state == ST_IDLE) && !clear_start && w_found;

    // One-hot ready toward the winning requester
    always_comb begin
        req_ready = '0;
        if (w_grant_en) begin
            req_ready[w_win_idx] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Control FSM with registered write port and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_rr         <= '0;
            r_cnt        <= '0;
            r_we3        <= 1'b0;
            r_wa3        <= '0;
            r_wd3        <= '0;
            r_busy       <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (clear_start) begin
                        // The first sweep write (x1) is issued on entry, so the
                        // counter already points at x2.
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_we3   <= 1'b1;
                        r_wa3   <= AW'(1);
                        r_wd3   <= '0;
                        r_cnt   <= AW'(2);
                    end else if (w_found) begin
                        r_rr <= rr_index(w_win_idx, 1);
                        // x0 is hard-wired zero: complete the handshake, drop the write
                        if (w_win_addr != '0) begin
                            r_we3 <= 1'b1;
                            r_wa3 <= w_win_addr;
                            r_wd3 <= w_win_data;
                        end else begin
                            r_we3 <= 1'b0;
                        end
                    end else begin
                        r_we3 <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == '0) begin
                        // Counter wrapped: the top register was written this cycle
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_clear_done <= 1'b1;
                        r_we3        <= 1'b0;
                    end else begin
                        r_we3 <= 1'b1;
                        r_wa3 <= r_cnt;
                        r_wd3 <= '0;
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_we3   <= 1'b0;
                end
            endcase
        end
    end

    assign we3        = r_we3;
    assign wa3        = r_wa3;
    assign wd3        = r_wd3;
    assign busy       = r_busy;
    assign clear_done = r_clear_done;

endmodule
